// File: rtl/ladder_row_reader_if.sv
// Bus between the ladder sprite row reader and its surroundings
// (video timing, sprite ROM, pixel mixer).
//
// Handshake semantics: there is no valid/ready pair on this bus. line_start
// and pixel_ce are single-Clk strobes with no backpressure. next_y/ladder_x/
// ladder_y are meaningful only while line_start=1, and draw_x only while
// pixel_ce=1. rom_data is a combinational function of rom_addr and is
// consumed exactly once per line, in the cycle after rom_addr is loaded.
// busy, ladder_on, rom_addr and state are registered (busy is decoded from
// the registered state).
interface ladder_row_reader_if #(
  parameter int SPRITE_W = 14
);
  logic                line_start;
  logic [9:0]          next_y;
  logic [9:0]          ladder_x;
  logic [9:0]          ladder_y;
  logic                pixel_ce;
  logic [9:0]          draw_x;
  logic [5:0]          rom_addr;
  logic [SPRITE_W-1:0] rom_data;
  logic                ladder_on;
  logic                busy;
  logic [2:0]          state;    // debug view of the row-reader FSM

  // Stimulus side: video timing plus the sprite ROM.
  modport master (
    output line_start, next_y, ladder_x, ladder_y, pixel_ce, draw_x, rom_data,
    input  rom_addr, ladder_on, busy, state
  );

  // Row reader side.
  modport slave (
    input  line_start, next_y, ladder_x, ladder_y, pixel_ce, draw_x, rom_data,
    output rom_addr, ladder_on, busy, state
  );
endinterface

// File: rtl/ladder_row_reader.sv
// Ladder sprite row reader: during hblank it fetches one sprite row from the
// ROM, then serialises it MSB-first onto ladder_on, starting at the pixel
// whose column equals the sprite's left edge.
module ladder_row_reader #(
  parameter int SPRITE_W = 14,
  parameter int SPRITE_H = 50
) (
  input logic              Clk,
  input logic              Reset,
  ladder_row_reader_if.slave bus
);
  localparam int COL_W = $clog2(SPRITE_W + 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ADDR  = 3'd1,
    LATCH = 3'd2,
    ARMED = 3'd3,
    SHIFT = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic [5:0]          row_q, row_d;
  logic [9:0]          x_q, x_d;
  logic [5:0]          rom_addr_q, rom_addr_d;
  logic [SPRITE_W-1:0] bits_q, bits_d;
  logic [COL_W-1:0]    col_q, col_d;
  logic                on_q, on_d;
  logic                busy;

  // Row offset at 11 bits so that next_y < ladder_y shows up as bit 10 set.
  logic [10:0]         row_calc;
  logic                row_ok;
  logic                x_hit;
  logic [SPRITE_W-1:0] bits_shifted;
  logic                col_done;

  assign row_calc     = {1'b0, bus.next_y} - {1'b0, bus.ladder_y};
  assign row_ok       = ~row_calc[10] && (row_calc < 11'(SPRITE_H));
  assign x_hit        = bus.pixel_ce && (bus.draw_x == x_q);
  // Bit to emit is always the MSB of the row shifted left by the column.
  assign bits_shifted = bits_q << col_q;
  assign col_done     = (col_q == COL_W'(SPRITE_W));

  // State register.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic; line_start overrides whatever the FSM is doing.
  always_comb begin
    state_d = state_q;
    if (bus.line_start) begin
      state_d = row_ok ? ADDR : IDLE;
    end else begin
      case (state_q)
        IDLE:    state_d = IDLE;
        ADDR:    state_d = LATCH;
        LATCH:   state_d = ARMED;
        ARMED:   if (x_hit) state_d = SHIFT;
        SHIFT:   if (bus.pixel_ce && col_done) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Datapath next values: line latch, ROM address, row capture, serialiser.
  always_comb begin
    row_d      = row_q;
    x_d        = x_q;
    rom_addr_d = rom_addr_q;
    bits_d     = bits_q;
    col_d      = col_q;
    on_d       = on_q;
    if (bus.line_start) begin
      row_d = row_calc[5:0];
      x_d   = bus.ladder_x;
      col_d = '0;
      on_d  = 1'b0;
    end else begin
      case (state_q)
        ADDR:  rom_addr_d = row_q;
        LATCH: bits_d     = bus.rom_data;
        ARMED: begin
          if (x_hit) begin
            on_d  = bits_q[SPRITE_W-1];
            col_d = COL_W'(1);
          end
        end
        SHIFT: begin
          if (bus.pixel_ce) begin
            if (col_done) begin
              on_d  = 1'b0;
              col_d = '0;
            end else begin
              on_d  = bits_shifted[SPRITE_W-1];
              col_d = col_q + COL_W'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Datapath registers.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      row_q      <= '0;
      x_q        <= '0;
      rom_addr_q <= '0;
      bits_q     <= '0;
      col_q      <= '0;
      on_q       <= 1'b0;
    end else begin
      row_q      <= row_d;
      x_q        <= x_d;
      rom_addr_q <= rom_addr_d;
      bits_q     <= bits_d;
      col_q      <= col_d;
      on_q       <= on_d;
    end
  end

  // Outputs decoded from registered state.
  always_comb begin
    busy = (state_q == ADDR) || (state_q == LATCH);
  end

  assign bus.busy      = busy;
  assign bus.rom_addr  = rom_addr_q;
  assign bus.ladder_on = on_q;
  assign bus.state     = state_q;

endmodule

// File: tb/tb_ladder_row_reader.sv
module tb_ladder_row_reader;
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ADDR  = 3'd1;
  localparam logic [2:0] S_LATCH = 3'd2;
  localparam logic [2:0] S_ARMED = 3'd3;
  localparam logic [2:0] S_SHIFT = 3'd4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ladder_row_reader_if #(.SPRITE_W(14)) bus();

  ladder_row_reader #(.SPRITE_W(14), .SPRITE_H(50)) dut (
    .Clk   (clk),
    .Reset (rst),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  logic [0:0] exp_q[$];

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Advance past the next rising edge; outputs are sampled 1ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pixel(input int x);
    bus.pixel_ce = 1'b1;
    bus.draw_x   = 10'(x);
    tick();
    bus.pixel_ce = 1'b0;
  endtask

  // Issue line_start for sprite at (100,200), walk the two fetch cycles and
  // corrupt the position inputs/ROM afterwards to prove they were latched.
  task automatic start_line(input logic [9:0] y, input logic in_range,
                            input logic [5:0] addr, input logic [13:0] rom,
                            input logic ce_in_fetch);
    bus.ladder_x   = 10'd100;
    bus.ladder_y   = 10'd200;
    bus.next_y     = y;
    bus.rom_data   = rom;
    bus.line_start = 1'b1;
    tick();
    bus.line_start = 1'b0;
    bus.ladder_x   = 10'd0;
    bus.ladder_y   = 10'd0;
    bus.next_y     = 10'd0;
    bus.pixel_ce   = ce_in_fetch;
    bus.draw_x     = 10'd100;
    check($sformatf("ls%0d_on", y),    bus.ladder_on, 1'b0);
    check($sformatf("ls%0d_busy1", y), bus.busy, in_range);
    check($sformatf("ls%0d_st1", y),   bus.state, in_range ? S_ADDR : S_IDLE);
    tick();
    check($sformatf("ls%0d_busy2", y), bus.busy, in_range);
    check($sformatf("ls%0d_st2", y),   bus.state, in_range ? S_LATCH : S_IDLE);
    if (in_range) check($sformatf("ls%0d_addr", y), bus.rom_addr, addr);
    tick();
    bus.pixel_ce = 1'b0;
    bus.rom_data = ~rom;
    check($sformatf("ls%0d_busy3", y), bus.busy, 1'b0);
    check($sformatf("ls%0d_st3", y),   bus.state, in_range ? S_ARMED : S_IDLE);
    check($sformatf("ls%0d_on3", y),   bus.ladder_on, 1'b0);
  endtask

  // Sweep pixels from x_lo to 116 with 'gap' idle clocks between pixel_ce
  // pulses; the sprite occupies columns 100..113 with 'pat' MSB at 100.
  task automatic scan(input string name, input int x_lo, input logic [13:0] pat, input int gap);
    logic e;
    for (int x = x_lo; x <= 116; x++) begin
      exp_q.push_back((x >= 100 && x <= 113) ? pat[113 - x] : 1'b0);
      pixel(x);
      e = exp_q.pop_front();
      check($sformatf("%s_px%0d", name, x), bus.ladder_on, e);
      for (int g = 0; g < gap; g++) begin
        tick();
        check($sformatf("%s_hold%0d_%0d", name, x, g), bus.ladder_on, e);
      end
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst            = 1'b1;
    bus.line_start = 1'b0;
    bus.next_y     = '0;
    bus.ladder_x   = '0;
    bus.ladder_y   = '0;
    bus.pixel_ce   = 1'b0;
    bus.draw_x     = '0;
    bus.rom_data   = '0;
    #1;
    check("rst_state", bus.state, S_IDLE);
    check("rst_addr",  bus.rom_addr, 6'd0);
    check("rst_on",    bus.ladder_on, 1'b0);
    check("rst_busy",  bus.busy, 1'b0);
    repeat (3) tick();
    rst = 1'b0;
    tick();

    // Solid row 3.
    start_line(10'd203, 1'b1, 6'd3, 14'h3FFF, 1'b0);
    scan("solid", 98, 14'h3FFF, 0);
    check("solid_end_state", bus.state, S_IDLE);

    // Edge-only row 5.
    start_line(10'd205, 1'b1, 6'd5, 14'b11000000000011, 1'b0);
    scan("edges", 98, 14'b11000000000011, 0);

    // Out of range above and below the sprite.
    start_line(10'd199, 1'b0, 6'd0, 14'h3FFF, 1'b0);
    scan("above", 98, 14'h0000, 0);
    start_line(10'd250, 1'b0, 6'd0, 14'h3FFF, 1'b0);
    scan("below", 98, 14'h0000, 0);

    // First and last valid rows; pixel_ce during fetch must be ignored.
    start_line(10'd200, 1'b1, 6'd0, 14'b10010001000101, 1'b1);
    scan("top", 98, 14'b10010001000101, 0);
    start_line(10'd249, 1'b1, 6'd49, 14'b01101100110010, 1'b0);
    scan("bottom", 98, 14'b01101100110010, 0);

    // line_start mid-row aborts and restarts with row 10.
    start_line(10'd203, 1'b1, 6'd3, 14'h3FFF, 1'b0);
    for (int x = 100; x <= 105; x++) begin
      pixel(x);
      check($sformatf("abort_px%0d", x), bus.ladder_on, 1'b1);
    end
    check("abort_pre_state", bus.state, S_SHIFT);
    start_line(10'd210, 1'b1, 6'd10, 14'b10100000000001, 1'b0);
    scan("restart", 98, 14'b10100000000001, 0);

    // Asynchronous reset in the middle of a row.
    start_line(10'd203, 1'b1, 6'd3, 14'h3FFF, 1'b0);
    for (int x = 100; x <= 107; x++) pixel(x);
    check("arst_pre_on", bus.ladder_on, 1'b1);
    #2 rst = 1'b1;
    #1;
    check("arst_on",    bus.ladder_on, 1'b0);
    check("arst_addr",  bus.rom_addr, 6'd0);
    check("arst_state", bus.state, S_IDLE);
    check("arst_busy",  bus.busy, 1'b0);
    #2 rst = 1'b0;
    scan("post_rst", 108, 14'h0000, 0);
    scan("post_rst2", 98, 14'h0000, 0);

    // pixel_ce every 4th clock.
    start_line(10'd203, 1'b1, 6'd3, 14'h3FFF, 1'b0);
    scan("slow", 98, 14'h3FFF, 3);
    start_line(10'd205, 1'b1, 6'd5, 14'b11000000000011, 1'b0);
    scan("slow2", 98, 14'b11000000000011, 3);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
